// File: rtl/shiftreg_rx_if.sv
// rtl/shiftreg_rx_if.sv - serial-in / host-out bus of the shift-register receiver
// Signals:
//   serclk, ser_in   serial clock and data from the sender (asynchronous to clk)
//   read_rq          arm one word reception (level)
//   data_rq          pop request, rising edge pops one word
//   data             FIFO head word, 0 when empty
//   data_ready       FIFO not empty
//   busy             word reception in progress
//   level            words held in the FIFO
//   overflow         sticky: a completed word was dropped
// Modports: master = sender/host side, slave = receiver.
interface shiftreg_rx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) ();
    logic                       serclk;
    logic                       ser_in;
    logic                       read_rq;
    logic                       data_rq;
    logic [WIDTH-1:0]           data;
    logic                       data_ready;
    logic                       busy;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic                       overflow;

    modport master (
        output serclk, ser_in, read_rq, data_rq,
        input  data, data_ready, busy, level, overflow
    );

    modport slave (
        input  serclk, ser_in, read_rq, data_rq,
        output data, data_ready, busy, level, overflow
    );
endinterface

// File: rtl/shiftreg_rx.sv
// rtl/shiftreg_rx.sv - oversampled serial-input shift register with output word FIFO
// Ports:
//   clk    system clock, all logic on its rising edge
//   reset  synchronous, active-high
//   bus    shiftreg_rx_if.slave (serclk, ser_in, read_rq, data_rq in;
//          data, data_ready, busy, level, overflow out)
// Parameters: WIDTH bits per word, DEPTH FIFO words (power of two),
//   MSB_FIRST (1: first bit lands in data[WIDTH-1]), SAMPLE_EDGE (1: rising).
// Build option: SHIFTREG_RX_SYNC_EN adds a two-flop synchroniser on serclk/ser_in;
//   without it a single register stage is used (serclk derived from clk).
module shiftreg_rx #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int MSB_FIRST   = 1,
    parameter int SAMPLE_EDGE = 1
) (
    input  logic         clk,
    input  logic         reset,
    shiftreg_rx_if.slave bus
);
    localparam int   CW       = $clog2(WIDTH);
    localparam int   PW       = $clog2(DEPTH);
    localparam int   LW       = $clog2(DEPTH + 1);
    localparam logic EDGE_LVL = (SAMPLE_EDGE != 0);

    // ---------------- serial input capture ----------------
    logic sclk_sync;
    logic sin_sync;

`ifdef SHIFTREG_RX_SYNC_EN
    logic sclk_meta;
    logic sin_meta;

    always_ff @(posedge clk) begin
        sclk_meta <= bus.serclk;
        sin_meta  <= bus.ser_in;
        sclk_sync <= sclk_meta;
        sin_sync  <= sin_meta;
    end
`else
    always_ff @(posedge clk) begin
        sclk_sync <= bus.serclk;
        sin_sync  <= bus.ser_in;
    end
`endif

    // History always tracks the synchronised clock, in reset too, so the
    // first cycle after reset release can never see a false edge.
    logic sclk_hist;
    always_ff @(posedge clk) begin
        sclk_hist <= sclk_sync;
    end

    logic sample_edge;
    assign sample_edge = (sclk_sync != sclk_hist) && (sclk_sync == EDGE_LVL);

    // ---------------- word assembly FSM ----------------
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic             busy_q;
    logic             last_bit;
    logic             push;

    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST != 0) shreg_next = {shreg[WIDTH-2:0], sin_sync};
        else                shreg_next = {sin_sync, shreg[WIDTH-1:1]};
    end

    assign last_bit = (bit_cnt == CW'(WIDTH - 1));
    // The completed word is shreg_next on the edge that shifts its last bit.
    assign push     = (state == SHIFT) && sample_edge && last_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.read_rq) begin
                        state   <= SHIFT;
                        busy_q  <= 1'b1;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                SHIFT: begin
                    if (sample_edge) begin
                        shreg <= shreg_next;
                        if (last_bit) begin
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- pop request edge detect ----------------
    logic rq_q;
    logic rq_prev;
    logic pop_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            rq_q    <= 1'b0;
            rq_prev <= 1'b0;
        end else begin
            rq_q    <= bus.data_rq;
            rq_prev <= rq_q;
        end
    end

    assign pop_req = rq_q & ~rq_prev;

    // ---------------- output FIFO ----------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             ovf_q;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == LW'(DEPTH));
    assign pop_ok  = pop_req && (count != '0);
    // A simultaneous pop frees the slot, so a push at full still fits.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop_ok)      count <= count + LW'(1);
            else if (!push_ok && pop_ok) count <= count - LW'(1);
            if (push && !push_ok) ovf_q <= 1'b1;
        end
    end

    assign bus.data       = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.data_ready = (count != '0);
    assign bus.busy       = busy_q;
    assign bus.level      = count;
    assign bus.overflow   = ovf_q;
endmodule
